// File: rtl/simple_uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through RX FIFO.
// Bit period is clkdiv+1 clocks, matching simple_uart_tx.
module simple_uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] clkdiv,
  output logic [7:0]  fifo_out,
  input  logic        fifo_read,
  output logic        fifo_empty,
  output logic [7:0]  fifo_level,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned ENTRIES = 2 ** DEPTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t state, state_nxt;

  logic        rx_meta, rxs, rxs_prev;
  logic        fall;
  logic [15:0] baud_cnt;
  logic        tick;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        wr_pending;

  logic        load_half, start_ok, shift_en, byte_done, stop_bad;

  logic [7:0]       mem [ENTRIES];
  logic [DEPTH-1:0] wr_ptr, rd_ptr;
  logic [7:0]       count;
  logic             full, do_read, do_write;

  // rxs_prev trails rxs by one clock so a start edge is seen exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign fall = rxs_prev & ~rxs;
  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)            baud_cnt <= '0;
    else if (load_half) baud_cnt <= clkdiv >> 1;
    else if (tick)      baud_cnt <= clkdiv;
    else                baud_cnt <= baud_cnt - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (fall) state_nxt = S_START;
      S_START:   if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:    if (tick && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:    if (tick) state_nxt = rxs ? S_IDLE : S_WAIT_HI;
      S_WAIT_HI: if (rxs) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE:  load_half = fall;
      S_START: start_ok  = tick & ~rxs;
      S_DATA:  shift_en  = tick;
      S_STOP: begin
        byte_done = tick & rxs;
        stop_bad  = tick & ~rxs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= '0;
      shreg      <= '0;
      wr_pending <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (start_ok)      bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {rxs, shreg[7:1]};
      wr_pending <= byte_done;
      frame_err  <= stop_bad;
    end
  end

  assign fifo_empty = (count == '0);
  assign full       = (count == 8'(ENTRIES));
  assign do_read    = fifo_read & ~fifo_empty;
  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  assign do_write   = wr_pending & (~full | do_read);
  assign fifo_out   = mem[rd_ptr];
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
      overrun <= wr_pending & ~do_write;
    end
  end

endmodule

// File: tb/tb_simple_uart_rx_fifo.sv
// Directed bench for simple_uart_rx_fifo: a 16-entry and a 4-entry instance driven by
// bench-side serialisers, with hand-computed expected bytes, levels and flag counts.
module tb_simple_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clkdiv;
  logic        rx_a, rx_b;
  logic        fifo_read_a, fifo_read_b;
  logic [7:0]  fifo_out_a, fifo_out_b;
  logic        fifo_empty_a, fifo_empty_b;
  logic [7:0]  fifo_level_a, fifo_level_b;
  logic        frame_err_a, frame_err_b;
  logic        overrun_a, overrun_b;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_a = 0, ov_a = 0, fe_b = 0, ov_b = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  simple_uart_rx_fifo #(.DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .clkdiv(clkdiv),
    .fifo_out(fifo_out_a), .fifo_read(fifo_read_a), .fifo_empty(fifo_empty_a),
    .fifo_level(fifo_level_a), .frame_err(frame_err_a), .overrun(overrun_a)
  );

  simple_uart_rx_fifo #(.DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .clkdiv(clkdiv),
    .fifo_out(fifo_out_b), .fifo_read(fifo_read_b), .fifo_empty(fifo_empty_b),
    .fifo_level(fifo_level_b), .frame_err(frame_err_b), .overrun(overrun_b)
  );

  always @(posedge clk) begin
    if (frame_err_a) fe_a++;
    if (overrun_a)   ov_a++;
    if (frame_err_b) fe_b++;
    if (overrun_b)   ov_b++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * (int'(clkdiv) + 1)) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop_bit);
    drive(sel, 1'b0);
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      wait_bits(1);
    end
    drive(sel, stop_bit);
    wait_bits(1);
    drive(sel, 1'b1);
  endtask

  task automatic pop_check(input bit sel, input string tag, input int exp);
    if (sel) begin
      check(tag, fifo_out_b, exp);
      fifo_read_b = 1'b1;
      @(negedge clk);
      fifo_read_b = 1'b0;
    end else begin
      check(tag, fifo_out_a, exp);
      fifo_read_a = 1'b1;
      @(negedge clk);
      fifo_read_a = 1'b0;
    end
  endtask

  task automatic loopback(input int n, input int unsigned div);
    int rcv = 0;
    int cyc = 0;
    int limit;
    int fe0, ov0;
    clkdiv = 16'(div);
    limit = n * (int'(div) + 1) * 10 + 400;
    fe0 = fe_a;
    ov0 = ov_a;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          send_byte(1'b0, b, 1'b1);
        end
      end
      begin
        while (rcv < n && cyc < limit) begin
          @(negedge clk);
          cyc++;
          fifo_read_a = 1'b0;
          if (!fifo_empty_a && $urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
            check("lb_data", fifo_out_a, exp_q.pop_front());
            fifo_read_a = 1'b1;
            rcv++;
          end
        end
        @(negedge clk);
        fifo_read_a = 1'b0;
      end
    join
    check("lb_count", rcv, n);
    check("lb_frame_err", fe_a - fe0, 0);
    check("lb_overrun", ov_a - ov0, 0);
    check("lb_empty", fifo_empty_a, 1);
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int fe0, ov0;
    rst = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    fifo_read_a = 1'b0;
    fifo_read_b = 1'b0;
    clkdiv = 16'd15;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_empty_a", fifo_empty_a, 1);
    check("rst_level_a", fifo_level_a, 0);
    check("rst_ferr_a", frame_err_a, 0);
    check("rst_ovr_a", overrun_a, 0);
    check("rst_empty_b", fifo_empty_b, 1);
    check("rst_level_b", fifo_level_b, 0);
    repeat (4) @(negedge clk);

    // 1: single byte at 16 clk/bit
    send_byte(1'b0, 8'hA5, 1'b1);
    wait_bits(1);
    check("t1_empty", fifo_empty_a, 0);
    check("t1_level", fifo_level_a, 1);
    pop_check(1'b0, "t1_data", 8'hA5);
    check("t1_empty_after", fifo_empty_a, 1);

    // 2: short low glitch is ignored, following frame intact
    fe0 = fe_a;
    ov0 = ov_a;
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    wait_bits(2);
    check("t2_level", fifo_level_a, 0);
    check("t2_flags", (fe_a - fe0) + (ov_a - ov0), 0);
    send_byte(1'b0, 8'h3C, 1'b1);
    wait_bits(1);
    check("t2_level_after", fifo_level_a, 1);
    pop_check(1'b0, "t2_data", 8'h3C);

    // 3: bad stop bit followed by a long break
    fe0 = fe_a;
    send_byte(1'b0, 8'h3C, 1'b0);
    rx_a = 1'b0;
    wait_bits(40);
    rx_a = 1'b1;
    wait_bits(2);
    check("t3_frame_err", fe_a - fe0, 1);
    check("t3_level", fifo_level_a, 0);
    send_byte(1'b0, 8'h81, 1'b1);
    wait_bits(1);
    check("t3_frame_err_after", fe_a - fe0, 1);
    pop_check(1'b0, "t3_data", 8'h81);

    // 4: overfill the 4-entry FIFO
    ov0 = ov_b;
    for (int i = 1; i <= 5; i++) send_byte(1'b1, 8'(i), 1'b1);
    wait_bits(1);
    check("t4_level", fifo_level_b, 4);
    check("t4_overrun", ov_b - ov0, 1);
    check("t4_frame_err", fe_b, 0);
    for (int i = 1; i <= 4; i++) pop_check(1'b1, "t4_data", i);
    check("t4_empty", fifo_empty_b, 1);

    // 5: write into a full FIFO while popping in the write cycle
    for (int i = 1; i <= 4; i++) send_byte(1'b1, 8'(8'h10 + i), 1'b1);
    wait_bits(1);
    check("t5_full_level", fifo_level_b, 4);
    ov0 = ov_b;
    fork
      send_byte(1'b1, 8'h05, 1'b1);
      begin
        // write cycle for clkdiv=15 spans the 155th negedge after the start bit
        repeat (155) @(negedge clk);
        check("t5_head", fifo_out_b, 8'h11);
        fifo_read_b = 1'b1;
        @(negedge clk);
        fifo_read_b = 1'b0;
      end
    join
    wait_bits(1);
    check("t5_level", fifo_level_b, 4);
    check("t5_overrun", ov_b - ov0, 0);
    pop_check(1'b1, "t5_data", 8'h12);
    pop_check(1'b1, "t5_data", 8'h13);
    pop_check(1'b1, "t5_data", 8'h14);
    pop_check(1'b1, "t5_last", 8'h05);

    // 6: back-to-back random traffic with a random reader
    loopback(64, 3);
    loopback(4, 867);

    clkdiv = 16'd15;
    wait_bits(1);
    fe0 = fe_a;
    ov0 = ov_a;
    rx_a = 1'b0;
    wait_bits(3);
    rst = 1'b1;
    rx_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_bits(12);
    check("t6_rst_level", fifo_level_a, 0);
    check("t6_rst_flags", (fe_a - fe0) + (ov_a - ov0), 0);
    send_byte(1'b0, 8'h5A, 1'b1);
    wait_bits(1);
    check("t6_rst_after_level", fifo_level_a, 1);
    pop_check(1'b0, "t6_rst_after_data", 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
